// File: rtl/astar_pkg.sv
// Shared constants and types for the A* path output stage.
// Holds grid/path limits, the 8-neighbour direction code, the streamer FSM states and a direction encoder.
package astar_pkg;

    localparam int COORD_W  = 8;
    localparam int MAX_PATH = 51;
    localparam int GRID_W   = 40;
    localparam int GRID_H   = 40;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // North is y-1; the caller guarantees a unit, non-zero step.
    function automatic dir_t dir_code(input logic x_pos, input logic x_neg,
                                      input logic y_pos, input logic y_neg);
        dir_t code;
        if (x_pos) begin
            code = y_neg ? DIR_NE : (y_pos ? DIR_SE : DIR_E);
        end else if (x_neg) begin
            code = y_neg ? DIR_NW : (y_pos ? DIR_SW : DIR_W);
        end else begin
            code = y_pos ? DIR_S : DIR_N;
        end
        return code;
    endfunction

endpackage

// File: rtl/path_lifo.sv
// Path node stack: array storage, occupancy pointer and a registered top-of-stack.
// top always mirrors mem[ptr-1]; a push forwards the incoming word so it is visible next cycle.
module path_lifo #(
    parameter int DEPTH  = 51,
    parameter int DATA_W = 16,
    localparam int PTR_W  = $clog2(DEPTH + 1),
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W-1:0]  ptr,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr_reg;
    logic [DATA_W-1:0] top_reg;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              do_push;
    logic              do_pop;

    assign full    = (ptr_reg == PTR_W'(DEPTH));
    assign empty   = (ptr_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign wr_addr = ADDR_W'(ptr_reg);
    // After a pop the new top is the entry below the current one.
    assign rd_addr = (ptr_reg >= PTR_W'(2)) ? ADDR_W'(ptr_reg - PTR_W'(2)) : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
            top_reg <= '0;
        end else if (do_push) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
            top_reg <= din;
        end else if (do_pop) begin
            ptr_reg <= ptr_reg - PTR_W'(1);
            top_reg <= mem[rd_addr];
        end
    end

    assign top = top_reg;
    assign ptr = ptr_reg;

endmodule

// File: rtl/path_reverse_streamer.sv
// Buffers a goal-to-start path in a LIFO and replays it start-to-goal on a valid/ready stream.
// Optional per-step direction tagging and adjacency checking is enabled by defining PATH_DIR_EN.
module path_reverse_streamer
    import astar_pkg::*;
#(
    parameter int COORD_W_P  = astar_pkg::COORD_W,
    parameter int MAX_PATH_P = astar_pkg::MAX_PATH,
    parameter int GRID_W_P   = astar_pkg::GRID_W,
    parameter int GRID_H_P   = astar_pkg::GRID_H,
    localparam int LEN_W     = $clog2(MAX_PATH_P + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COORD_W_P-1:0] in_x,
    input  logic [COORD_W_P-1:0] in_y,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COORD_W_P-1:0] out_x,
    output logic [COORD_W_P-1:0] out_y,
    output logic                 out_last,
    output logic [2:0]           out_dir,
    output logic                 out_dir_vld,
    output logic [LEN_W-1:0]     path_len,
    output logic                 err_overflow,
    output logic                 err_range,
    output logic                 err_adj
);

    localparam logic [COORD_W_P-1:0] X_LIM = COORD_W_P'(GRID_W_P);
    localparam logic [COORD_W_P-1:0] Y_LIM = COORD_W_P'(GRID_H_P);

    state_t                   state_reg, state_next;
    logic [2*COORD_W_P-1:0]   top_node;
    logic [COORD_W_P-1:0]     cur_x, cur_y;
    logic [LEN_W-1:0]         lifo_ptr;
    logic                     lifo_full, lifo_empty;
    logic                     in_fire, out_fire, drain_valid, last_beat;
    logic [LEN_W-1:0]         path_len_reg;
    logic                     err_overflow_reg, err_range_reg;

    path_lifo #(
        .DEPTH  (MAX_PATH_P),
        .DATA_W (2 * COORD_W_P)
    ) u_lifo (
        .clk   (Clk),
        .srst  (Reset),
        .push  (in_fire),
        .pop   (out_fire),
        .din   ({in_x, in_y}),
        .top   (top_node),
        .ptr   (lifo_ptr),
        .full  (lifo_full),
        .empty (lifo_empty)
    );

    assign cur_x       = top_node[2*COORD_W_P-1:COORD_W_P];
    assign cur_y       = top_node[COORD_W_P-1:0];
    assign drain_valid = (state_reg == DRAIN) && !lifo_empty;
    assign last_beat   = drain_valid && (lifo_ptr == LEN_W'(1));
    assign out_fire    = drain_valid && out_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        in_fire    = 1'b0;
        case (state_reg)
            FILL: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                // A dropped start node still closes the path.
                if (in_valid && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && last_beat) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            path_len_reg     <= '0;
            err_overflow_reg <= 1'b0;
            err_range_reg    <= 1'b0;
        end else begin
            if (in_fire && !lifo_full) begin
                path_len_reg <= lifo_ptr + LEN_W'(1);
            end else if (out_fire && last_beat) begin
                path_len_reg <= '0;
            end
            if (in_fire && lifo_full) begin
                err_overflow_reg <= 1'b1;
            end
            if (in_fire && ((in_x >= X_LIM) || (in_y >= Y_LIM))) begin
                err_range_reg <= 1'b1;
            end
        end
    end

    assign out_valid    = drain_valid;
    assign out_x        = drain_valid ? cur_x : '0;
    assign out_y        = drain_valid ? cur_y : '0;
    assign out_last     = last_beat;
    assign path_len     = path_len_reg;
    assign err_overflow = err_overflow_reg;
    assign err_range    = err_range_reg;

`ifdef PATH_DIR_EN
    localparam logic signed [COORD_W_P:0] D_ONE = 1;

    logic [COORD_W_P-1:0]     prev_x_reg, prev_y_reg;
    logic                     have_prev_reg, err_adj_reg;
    logic signed [COORD_W_P:0] dx, dy;
    logic                     unit_step, step_ok;
    dir_t                     dir_cur;

    // Differences are taken one bit wider so they are signed without wrapping.
    assign dx        = $signed({1'b0, cur_x}) - $signed({1'b0, prev_x_reg});
    assign dy        = $signed({1'b0, cur_y}) - $signed({1'b0, prev_y_reg});
    assign unit_step = (dx <= D_ONE) && (dx >= -D_ONE) && (dy <= D_ONE) && (dy >= -D_ONE);
    assign step_ok   = unit_step && ((dx != '0) || (dy != '0));
    assign dir_cur   = dir_code(!dx[COORD_W_P] && (dx != '0), dx[COORD_W_P],
                                !dy[COORD_W_P] && (dy != '0), dy[COORD_W_P]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_x_reg    <= '0;
            prev_y_reg    <= '0;
            have_prev_reg <= 1'b0;
            err_adj_reg   <= 1'b0;
        end else if (out_fire) begin
            prev_x_reg    <= cur_x;
            prev_y_reg    <= cur_y;
            have_prev_reg <= !last_beat;
            if (have_prev_reg && !step_ok) begin
                err_adj_reg <= 1'b1;
            end
        end
    end

    assign out_dir_vld = drain_valid && have_prev_reg && step_ok;
    assign out_dir     = out_dir_vld ? dir_cur : DIR_N;
    assign err_adj     = err_adj_reg;
`else
    assign out_dir     = DIR_N;
    assign out_dir_vld = 1'b0;
    assign err_adj     = 1'b0;
`endif

endmodule

// File: tb/tb_path_reverse_streamer.sv
// Directed and random bench for path_reverse_streamer against a queue-based LIFO reference model.
// Direction expectations follow PATH_DIR_EN when it is defined for the build.
module tb_path_reverse_streamer;

    localparam int MAX_PATH = 51;
    localparam int GRID     = 40;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } node_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = '0;
    logic [7:0] in_y = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_x, out_y;
    logic       out_last;
    logic [2:0] out_dir;
    logic       out_dir_vld;
    logic [5:0] path_len;
    logic       err_overflow, err_range, err_adj;

    path_reverse_streamer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_last     (out_last),
        .out_dir      (out_dir),
        .out_dir_vld  (out_dir_vld),
        .path_len     (path_len),
        .err_overflow (err_overflow),
        .err_range    (err_range),
        .err_adj      (err_adj)
    );

    always #5 Clk = ~Clk;

    int    errors = 0;
    int    checks = 0;
    node_t src[$];
    node_t stk[$];
    bit    exp_ovf, exp_rng, exp_adj, have_prev;
    int    exp_len;
    node_t prev;
    int    dxt[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int    dyt[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        exp_ovf = 0; exp_rng = 0; exp_adj = 0; have_prev = 0;
        exp_len = 0;
        prev = '0;
    endtask

    // Direction of the step prev -> cur by table lookup; bad marks a non-neighbour step.
    function automatic void calc_dir(input node_t cur, output bit vld, output int code, output bit bad);
        int dx, dy;
        dx = int'(cur.x) - int'(prev.x);
        dy = int'(cur.y) - int'(prev.y);
        vld = 0; code = 0; bad = 0;
        if (have_prev) begin
            for (int d = 0; d < 8; d++) begin
                if (dxt[d] == dx && dyt[d] == dy) begin
                    vld = 1; code = d;
                end
            end
            bad = !vld;
        end
`ifndef PATH_DIR_EN
        vld = 0; code = 0; bad = 0;
`endif
    endfunction

    task automatic add(input int x, input int y);
        node_t n;
        n.x = 8'(x); n.y = 8'(y);
        src.push_back(n);
    endtask

    task automatic do_reset();
        Reset = 1; in_valid = 0; in_last = 0; out_ready = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        model_reset();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_x", 32'(out_x), 0);
        chk("rst_path_len", 32'(path_len), 0);
        chk("rst_errs", {29'd0, err_overflow, err_range, err_adj}, 0);
        Reset = 0;
    endtask

    task automatic push_path();
        int n = src.size();
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            chk("in_ready_fill", 32'(in_ready), 1);
            in_valid = 1; in_x = src[i].x; in_y = src[i].y; in_last = (i == n - 1);
            @(posedge Clk);
            if (stk.size() < MAX_PATH) stk.push_back(src[i]);
            else exp_ovf = 1;
            if (src[i].x >= GRID || src[i].y >= GRID) exp_rng = 1;
            exp_len = stk.size();
        end
        src.delete();
    endtask

    // mode 0: always ready, 1: ready toggles 1010, 2: random. max_pops 0 drains the whole path.
    task automatic drain(input int mode, input int max_pops);
        int pops = 0;
        int cyc = 0;
        bit done = 0;
        bit first = 1;
        bit v, rdy, evld, ebad, elast;
        int ecode;
        node_t e;
        while (!done && cyc < 500) begin
            @(negedge Clk);
            in_valid = 0; in_last = 0;
            v = out_valid;
            if (first) chk("first_valid_latency", 32'(v), 1);
            first = 0;
            chk("in_ready_drain", 32'(in_ready), 0);
            chk("path_len_hold", 32'(path_len), 32'(exp_len));
            elast = 0; evld = 0; ebad = 0; ecode = 0; e = '0;
            if (stk.size() > 0) begin
                e = stk[$];
                elast = (stk.size() == 1);
                calc_dir(e, evld, ecode, ebad);
                chk("out_valid", 32'(v), 1);
                chk("out_x", 32'(out_x), 32'(e.x));
                chk("out_y", 32'(out_y), 32'(e.y));
                chk("out_last", 32'(out_last), 32'(elast));
                chk("out_dir_vld", 32'(out_dir_vld), 32'(evld));
                chk("out_dir", 32'(out_dir), ecode);
            end
            case (mode)
                0:       rdy = 1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            @(posedge Clk);
            if (v && rdy && stk.size() > 0) begin
                if (ebad) exp_adj = 1;
                prev = e;
                have_prev = !elast;
                void'(stk.pop_back());
                pops++;
                if (elast) begin
                    exp_len = 0;
                    done = 1;
                end else if (max_pops > 0 && pops == max_pops) begin
                    done = 1;
                end
            end
            cyc++;
        end
        chk("drain_done", 32'(done), 1);
    endtask

    task automatic post_check(input string tag);
        @(negedge Clk);
        out_ready = 0;
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_path_len"}, 32'(path_len), 0);
        chk({tag, "_err_overflow"}, 32'(err_overflow), 32'(exp_ovf));
        chk({tag, "_err_range"}, 32'(err_range), 32'(exp_rng));
        chk({tag, "_err_adj"}, 32'(err_adj), 32'(exp_adj));
    endtask

    initial begin
        int len, x, y;
        do_reset();

        // Basic four-node path, consumer always ready.
        add(5, 5); add(5, 4); add(4, 3); add(3, 3);
        push_path();
        drain(0, 0);
        post_check("t1");

        // Same path with back-pressure toggling.
        add(5, 5); add(5, 4); add(4, 3); add(3, 3);
        push_path();
        drain(1, 0);
        post_check("t2");

        // Single-node path.
        add(7, 9);
        push_path();
        drain(0, 0);
        post_check("t6");

        // 52 nodes into a 51-deep stack: the start node is dropped but still ends the path.
        for (int i = 0; i < 52; i++) begin
            if (i < 40) add(i, 0);
            else add(39, i - 39);
        end
        push_path();
        chk("ovf_path_len", 32'(exp_len), 32'(MAX_PATH));
        drain(2, 0);
        post_check("t3");

        // Out-of-grid node and a non-neighbour jump.
        add(40, 2); add(1, 1);
        push_path();
        drain(0, 0);
        post_check("t4");

        // Reset after two of four pops, then a fresh path.
        add(2, 2); add(2, 3); add(3, 4); add(4, 4);
        push_path();
        drain(0, 2);
        @(negedge Clk);
        out_ready = 0; Reset = 1;
        @(posedge Clk);
        @(negedge Clk);
        model_reset();
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_path_len", 32'(path_len), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        Reset = 0;
        add(8, 8); add(9, 9);
        push_path();
        drain(0, 0);
        post_check("t5");

        // Random walks with occasional jumps, random back-pressure.
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 10);
            x = $urandom_range(10, 29);
            y = $urandom_range(10, 29);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    x = $urandom_range(0, 45);
                    y = $urandom_range(0, 45);
                end else if (i > 0) begin
                    x = x + $urandom_range(0, 2) - 1;
                    y = y + $urandom_range(0, 2) - 1;
                end
                add(x, y);
            end
            push_path();
            drain(2, 0);
            post_check("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
